hazard_flush_ctrl: RTL and testbench

HAZARD_FLUSH_CTRL -- requirements
Module: hazard_flush_ctrl

---
 rtl/hazard_flush_ctrl_if.sv | 34 +++
 rtl/hazard_flush_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_flush_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline hazard/flush control bundle: ID/EX hazard inputs, memory handshake,
// and the stall/flush/freeze controls and event counters.
interface hazard_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_readdmem;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             flush;
  logic             ifid_flush;
  logic             pc_redirect;
  logic             freeze;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_readdmem, ex_rd, ex_branch_taken, mem_ready,
    input  pc_write, ifid_write, flush, ifid_flush, pc_redirect, freeze, state,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_readdmem, ex_rd, ex_branch_taken, mem_ready,
    output pc_write, ifid_write, flush, ifid_flush, pc_redirect, freeze, state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Load-use stall, taken-branch flush sequencing and data-memory wait freeze,
// with saturating stall/flush event counters.
module hazard_flush_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_flush_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_RSVD  = 2'd1,
    S_FLUSH = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [2:0]       LP_REM_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;

  state_t           r_state, r_resume;
  state_t           w_state_nxt, w_resume_nxt, w_act;
  logic [2:0]       r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_lu;
  logic             w_pc_write, w_ifid_write, w_flush, w_ifid_flush, w_pc_redirect, w_freeze;

  assign w_lu = bus.ex_readdmem && (bus.ex_rd != 5'd0) &&
                ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));

  always_comb begin
    w_state_nxt   = S_RUN;
    w_resume_nxt  = S_RUN;
    w_rem_nxt     = r_rem;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_flush       = 1'b0;
    w_ifid_flush  = 1'b0;
    w_pc_redirect = 1'b0;
    w_freeze      = 1'b0;
    // A released WAIT cycle behaves exactly like a cycle of the state it interrupted.
    w_act         = (r_state == S_WAIT) ? r_resume : r_state;

    if (!bus.mem_ready) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_freeze     = 1'b1;
      w_state_nxt  = S_WAIT;
      w_resume_nxt = (w_act == S_FLUSH) ? S_FLUSH : S_RUN;
    end else if (w_act == S_FLUSH) begin
      w_flush      = 1'b1;
      w_ifid_flush = 1'b1;
      if (r_rem <= 3'd1) begin
        w_rem_nxt = 3'd0;
      end else begin
        w_rem_nxt   = r_rem - 3'd1;
        w_state_nxt = S_FLUSH;
      end
    end else if (bus.ex_branch_taken) begin
      w_pc_redirect = 1'b1;
      w_flush       = 1'b1;
      w_ifid_flush  = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = S_FLUSH;
        w_rem_nxt   = LP_REM_INIT;
      end
    end else if (w_lu) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_flush      = 1'b1;
    end

    if (rst) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_flush       = 1'b1;
      w_ifid_flush  = 1'b1;
      w_pc_redirect = 1'b0;
      w_freeze      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_resume <= S_RUN;
      r_rem    <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
      r_rem    <= w_rem_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_write && (r_stall_cnt != LP_CNT_MAX)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != LP_CNT_MAX))     r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.flush       = w_flush;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.pc_redirect = w_pc_redirect;
  assign bus.freeze      = w_freeze;
  assign bus.state       = r_state;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=3/CNT_W=4) sharing inputs, checked against a flush-debt model.
module tb_hazard_flush_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_flush_ctrl_if #(.CNT_W(16)) bus ();
  hazard_flush_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus4.id_rs           = bus.id_rs;
  assign bus4.id_rt           = bus.id_rt;
  assign bus4.id_uses_rt      = bus.id_uses_rt;
  assign bus4.ex_readdmem     = bus.ex_readdmem;
  assign bus4.ex_rd           = bus.ex_rd;
  assign bus4.ex_branch_taken = bus.ex_branch_taken;
  assign bus4.mem_ready       = bus.mem_ready;

  hazard_flush_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  hazard_flush_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int checks = 0;
  int errors = 0;

  // Model: flush cycles still owed, whether the last edge saw a memory wait, counters.
  int fc_tab  [2] = '{2, 3};
  int max_tab [2] = '{65535, 15};
  int m_left  [2];
  bit m_wait  [2];
  int m_stall [2];
  int m_flush [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  function automatic logic lu_now();
    return bus.ex_readdmem && (bus.ex_rd != 5'd0) &&
           ((bus.ex_rd == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rd == bus.id_rt)));
  endfunction

  // {pc_write, ifid_write, flush, ifid_flush, pc_redirect, freeze, state}
  function automatic logic [7:0] exp_out(int k);
    logic [1:0] st;
    st = m_wait[k] ? 2'd3 : ((m_left[k] > 0) ? 2'd2 : 2'd0);
    if (rst)                  return 8'b0011_0000;
    if (!bus.mem_ready)       return {6'b000001, st};
    if (m_left[k] > 0)        return {6'b111100, st};
    if (bus.ex_branch_taken)  return {6'b111110, st};
    if (lu_now())             return {6'b001000, st};
    return {6'b110000, st};
  endfunction

  function automatic logic [7:0] obs(int k);
    if (k == 0)
      return {bus.pc_write, bus.ifid_write, bus.flush, bus.ifid_flush,
              bus.pc_redirect, bus.freeze, bus.state};
    return {bus4.pc_write, bus4.ifid_write, bus4.flush, bus4.ifid_flush,
            bus4.pc_redirect, bus4.freeze, bus4.state};
  endfunction

  function automatic logic [31:0] cnt_obs(int k);
    if (k == 0) return {bus.stall_cnt, bus.flush_cnt};
    return {12'd0, bus4.stall_cnt, 12'd0, bus4.flush_cnt};
  endfunction

  function automatic logic [31:0] cnt_exp(int k);
    return {16'(m_stall[k]), 16'(m_flush[k])};
  endfunction

  task automatic set_in(input int rs, input int rt, input bit ut, input bit ld,
                        input int rd, input bit br, input bit mr);
    bus.id_rs = 5'(rs); bus.id_rt = 5'(rt); bus.id_uses_rt = ut;
    bus.ex_readdmem = ld; bus.ex_rd = 5'(rd);
    bus.ex_branch_taken = br; bus.mem_ready = mr;
  endtask

  // Advance one clock and the model; no checking here.
  task automatic tick();
    logic [7:0] e [2];
    bit mr, br;
    for (int k = 0; k < 2; k++) e[k] = exp_out(k);
    mr = bus.mem_ready; br = bus.ex_branch_taken;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!e[k][7] && m_stall[k] < max_tab[k]) m_stall[k]++;
      if (e[k][5] && m_flush[k] < max_tab[k])  m_flush[k]++;
      if (!mr) m_wait[k] = 1'b1;
      else begin
        m_wait[k] = 1'b0;
        if (m_left[k] > 0) m_left[k]--;
        else if (br)       m_left[k] = fc_tab[k] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(3, 4, 1, 1, 3, 1, 0);
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp_out(k)) begin
        errors++; $display("FAIL reset_out[%0d]: got %b want %b", k, obs(k), exp_out(k));
      end
      checks++;
      if (cnt_obs(k) !== 32'd0) begin
        errors++; $display("FAIL reset_cnt[%0d]: got %h want 0", k, cnt_obs(k));
      end
    end
  endtask

  task automatic test_load_use();
    // rs, rt, uses_rt, load, rd
    int tab [6][5] = '{'{5,0,0,1,5}, '{0,0,0,0,0}, '{0,0,0,1,0}, '{1,7,1,1,7}, '{1,7,0,1,7}, '{9,9,1,0,9}};
    do_reset();
    for (int v = 0; v < 6; v++) begin
      set_in(tab[v][0], tab[v][1], tab[v][2] != 0, tab[v][3] != 0, tab[v][4], 0, 1);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++; $display("FAIL load_use_out[%0d] v%0d: got %b want %b", k, v, obs(k), exp_out(k));
        end
      end
      tick();
      if (v == 0) begin
        checks++;
        if (bus.stall_cnt !== 16'd1) begin
          errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", bus.stall_cnt);
        end
      end
    end
    checks++;
    if (bus.stall_cnt !== 16'd2) begin
      errors++; $display("FAIL load_use_total: got %0d want 2", bus.stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_in(0, 0, 0, 0, 0, c == 0, 1);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++; $display("FAIL branch_out[%0d] c%0d: got %b want %b", k, c, obs(k), exp_out(k));
        end
      end
      tick();
    end
    checks++;
    if (bus.flush_cnt !== 16'd2 || bus4.flush_cnt !== 4'd3) begin
      errors++; $display("FAIL branch_flush_cnt: got %0d/%0d want 2/3", bus.flush_cnt, bus4.flush_cnt);
    end
  endtask

  task automatic test_branch_and_lu();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(5, 0, 0, 1, 5, c == 0, 1);
      if (c > 0) set_in(0, 0, 0, 0, 0, 0, 1);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++; $display("FAIL br_lu_out[%0d] c%0d: got %b want %b", k, c, obs(k), exp_out(k));
        end
      end
      tick();
    end
    checks++;
    if (bus.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL br_lu_stall_cnt: got %0d want 0", bus.stall_cnt);
    end
  endtask

  task automatic test_wait_in_flush();
    int frz = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(0, 0, 0, 0, 0, c == 0, !(c >= 1 && c <= 3));
      #1;
      if (bus.freeze) frz++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++; $display("FAIL wait_out[%0d] c%0d: got %b want %b", k, c, obs(k), exp_out(k));
        end
      end
      tick();
    end
    checks++;
    if (frz != 3 || bus.flush_cnt !== 16'd2 || bus.stall_cnt !== 16'd3) begin
      errors++; $display("FAIL wait_totals: got freeze %0d flush %0d stall %0d want 3 2 3",
                         frz, bus.flush_cnt, bus.stall_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cnt_obs(k) !== cnt_exp(k)) begin
        errors++; $display("FAIL wait_cnt[%0d]: got %h want %h", k, cnt_obs(k), cnt_exp(k));
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_in(6, 0, 0, 1, 6, 0, 1);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (cnt_obs(k) !== cnt_exp(k)) begin
          errors++; $display("FAIL sat_cnt[%0d] c%0d: got %h want %h", k, c, cnt_obs(k), cnt_exp(k));
        end
      end
      tick();
    end
    checks++;
    if (bus4.stall_cnt !== 4'd15 || bus.stall_cnt !== 16'd20) begin
      errors++; $display("FAIL sat_final: got %0d/%0d want 15/20", bus4.stall_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) != 0,
             $urandom_range(0, 1) != 0, $urandom_range(0, 3),
             $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++; $display("FAIL random_out[%0d] c%0d: got %b want %b", k, c, obs(k), exp_out(k));
        end
        checks++;
        if (cnt_obs(k) !== cnt_exp(k)) begin
          errors++; $display("FAIL random_cnt[%0d] c%0d: got %h want %h", k, c, cnt_obs(k), cnt_exp(k));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp_out(k) || cnt_obs(k) !== 32'd0) begin
        errors++; $display("FAIL rst_mid_flush[%0d]: got %b/%h want %b/0", k, obs(k), cnt_obs(k), exp_out(k));
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_out(k)) begin
          errors++; $display("FAIL rst_release[%0d] c%0d: got %b want %b", k, c, obs(k), exp_out(k));
        end
      end
      tick();
    end
    checks++;
    if (bus.flush_cnt !== 16'd0 || bus.state !== 2'd0) begin
      errors++; $display("FAIL rst_residual: got flush_cnt %0d state %0d want 0 0", bus.flush_cnt, bus.state);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_branch_and_lu();
    test_wait_in_flush();
    test_saturation();
    test_random();
    test_reset_mid_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
